spi_rx: RTL and testbench

SPI_RX -- requirements
Module: spi_rx

---
 rtl/spi_rx.sv | 157 +++++++++++++++
 tb/tb_spi_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// spi_rx: SPI slave receiver (mode 0, MSB first) with 2-flop input synchronizers.
// Words of DATA_WIDTH bits are presented on data_out with a one-cycle data_valid_out strobe.
// Optional macro SPI_RX_FRAME_ERR_EN adds frame_err_out, pulsed when a select period
// ends on a partial word.
module spi_rx #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    data_in,
    input  logic                    data_clk_in,
    input  logic                    sel_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid_out
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    output logic                    frame_err_out
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_RECEIVE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_data_s1;
    logic                    r_data_s2;
    logic                    r_dclk_s1;
    logic                    r_dclk_s2;
    logic                    r_dclk_prev;
    logic                    r_sel_s1;
    logic                    r_sel_s2;

    logic [CNT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-2:0]   r_shift;

    logic                    w_rise;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_clear;
    logic                    w_shift;
    logic                    w_done;
`ifdef SPI_RX_FRAME_ERR_EN
    logic                    w_abort;
`endif

    assign w_rise = r_dclk_s2 & ~r_dclk_prev;
    assign w_last = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
    // Word as it stands once the current serial bit is appended.
    assign w_word = {r_shift, r_data_s2};

    // Input synchronizers; idle levels are serial clock low, select high.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_data_s1   <= 1'b0;
            r_data_s2   <= 1'b0;
            r_dclk_s1   <= 1'b0;
            r_dclk_s2   <= 1'b0;
            r_dclk_prev <= 1'b0;
            r_sel_s1    <= 1'b1;
            r_sel_s2    <= 1'b1;
        end else begin
            r_data_s1   <= data_in;
            r_data_s2   <= r_data_s1;
            r_dclk_s1   <= data_clk_in;
            r_dclk_s2   <= r_dclk_s1;
            r_dclk_prev <= r_dclk_s2;
            r_sel_s1    <= sel_in;
            r_sel_s2    <= r_sel_s1;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath controls; a last bit arriving with deselect still completes.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
        w_abort     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_sel_s2) begin
                    w_state_nxt = ST_RECEIVE;
                    w_clear     = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (r_sel_s2) begin
                    w_state_nxt = ST_IDLE;
                    if (w_rise && w_last) begin
                        w_done = 1'b1;
                    end
`ifdef SPI_RX_FRAME_ERR_EN
                    else if (r_bit_cnt != '0) begin
                        w_abort = 1'b1;
                    end
`endif
                end else if (w_rise) begin
                    w_shift = 1'b1;
                    w_done  = w_last;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter, shift register and output word with its strobe.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (w_clear) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_done) begin
                r_bit_cnt      <= '0;
                data_out       <= w_word;
                data_valid_out <= 1'b1;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_shift   <= w_word[DATA_WIDTH-2:0];
            end
        end
    end

`ifdef SPI_RX_FRAME_ERR_EN
    // Frame error strobe for a select period closed on a partial word.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            frame_err_out <= 1'b0;
        end else begin
            frame_err_out <= w_abort;
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: directed and randomized SPI frames checked against a word-level model.
module tb_spi_rx;

    localparam int unsigned W = 16;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           data_in;
    logic           data_clk_in;
    logic           sel_in;
    logic [W-1:0]   data_out;
    logic           data_valid_out;
`ifdef SPI_RX_FRAME_ERR_EN
    logic           frame_err_out;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rise_cyc = 0;

    // Monitor observations
    logic [W-1:0] got_q[$];
    int           wide_pulses = 0;
    int           unstable = 0;
    int           max_lat = 0;
    int           ferr_cnt = 0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_dout = '0;

    // Model: expected words in order, last expected data_out, expected frame errors
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_last = '0;
    int           exp_ferr = 0;

    spi_rx #(.DATA_WIDTH(W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_clk_in    (data_clk_in),
        .sel_in         (sel_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out)
`ifdef SPI_RX_FRAME_ERR_EN
        ,
        .frame_err_out  (frame_err_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Observe outputs on the falling edge
    always @(negedge clk_in) begin
        if (data_valid_out) begin
            got_q.push_back(data_out);
            if (cyc - last_rise_cyc > max_lat) max_lat = cyc - last_rise_cyc;
            if (prev_valid) wide_pulses++;
        end else if (data_out !== prev_dout) begin
            unstable++;
        end
`ifdef SPI_RX_FRAME_ERR_EN
        if (frame_err_out === 1'b1) ferr_cnt++;
`endif
        prev_valid = data_valid_out;
        prev_dout  = data_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sclk_bit(input logic b);
        data_in = b;
        repeat ($urandom_range(4, 7)) @(negedge clk_in);
        data_clk_in   = 1'b1;
        last_rise_cyc = cyc;
        repeat ($urandom_range(4, 7)) @(negedge clk_in);
        data_clk_in = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) sclk_bit(w[W-1-i]);
    endtask

    task automatic select();
        sel_in = 1'b0;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic deselect();
        repeat (3) @(negedge clk_in);
        sel_in = 1'b1;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic expect_word(input logic [W-1:0] w);
        exp_q.push_back(w);
        exp_last = w;
    endtask

    task automatic verify(input string tag);
        repeat (8) @(negedge clk_in);
        check({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, "_dout"}, data_out, exp_last);
        check({tag, "_pulse_width"}, wide_pulses, 0);
        check({tag, "_hold"}, unstable, 0);
        check({tag, "_latency_le4"}, 32'(max_lat <= 4), 1);
`ifdef SPI_RX_FRAME_ERR_EN
        check({tag, "_frame_err"}, ferr_cnt, exp_ferr);
`endif
    endtask

    initial begin
        logic [W-1:0] w;
        int k;
        int p;

        rst_in      = 1'b0;
        data_in     = 1'b0;
        data_clk_in = 1'b0;
        sel_in      = 1'b1;
        repeat (3) @(negedge clk_in);
        check("reset_dout", data_out, 0);
        check("reset_valid", data_valid_out, 0);
`ifdef SPI_RX_FRAME_ERR_EN
        check("reset_ferr", frame_err_out, 0);
`endif
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);

        // Single word
        select();
        send_bits(16'hBEEF, 16);
        expect_word(16'hBEEF);
        deselect();
        verify("beef");

        // Two back-to-back words in one select
        select();
        send_bits(16'hBEEF, 16);
        expect_word(16'hBEEF);
        send_bits(16'hFEED, 16);
        expect_word(16'hFEED);
        deselect();
        verify("beef_feed");

        // Partial word aborted by deselect
        select();
        send_bits(16'hA5A5, 5);
        exp_ferr++;
        deselect();
        verify("partial");

        // Serial clock while not selected
        send_bits(16'hFFFF, 16);
        repeat (4) @(negedge clk_in);
        verify("unselected");

        // Last bit edge and deselect seen together
        select();
        w = 16'h3C96;
        send_bits(w, W - 1);
        data_in = w[0];
        repeat (5) @(negedge clk_in);
        data_clk_in   = 1'b1;
        sel_in        = 1'b1;
        last_rise_cyc = cyc;
        repeat (5) @(negedge clk_in);
        data_clk_in = 1'b0;
        expect_word(w);
        repeat (6) @(negedge clk_in);
        verify("last_bit_desel");

        // Reset mid-word, then reselect
        select();
        send_bits(16'h1234, 8);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        exp_last = '0;
        check("midreset_dout", data_out, exp_last);
        @(posedge clk_in);
        unstable = 0;
        deselect();
        select();
        send_bits(16'h5678, 16);
        expect_word(16'h5678);
        deselect();
        verify("after_reset");

        // Randomized frames: some full words followed by an optional partial tail
        for (int f = 0; f < 6; f++) begin
            select();
            k = int'($urandom_range(0, 2));
            for (int j = 0; j < k; j++) begin
                w = W'($urandom);
                send_bits(w, W);
                expect_word(w);
            end
            p = int'($urandom_range(0, W - 1));
            if (p > 0) begin
                send_bits(W'($urandom), p);
                exp_ferr++;
            end
            deselect();
            verify("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
